// File: rtl/spi_pkg.sv
// Shared types and helpers for the Clk-domain SPI slave.
// Mode encodings, FSM state type and a CPOL/CPHA decoder.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic spi_mode_t mode_decode(input logic [1:0] mode);
        spi_mode_t m;
        unique case (mode)
            MODE0:   begin m.cpol = 1'b0; m.cpha = 1'b0; end
            MODE1:   begin m.cpol = 1'b0; m.cpha = 1'b1; end
            MODE2:   begin m.cpol = 1'b1; m.cpha = 1'b0; end
            MODE3:   begin m.cpol = 1'b1; m.cpha = 1'b1; end
            default: begin m.cpol = 1'b0; m.cpha = 1'b0; end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus one extra flop that
// yields single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on Clk; SClk/SS/MOSI are oversampled pins, never clocks.
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB-first.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_FILL     = {DATA_WIDTH{1'b0}}
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [1:0]            MODE,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxValid,
    output logic                  TxReady,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
    output logic                  Underrun,
    output logic                  FrameErr,
    output logic                  Busy,
    input  logic                  SClk,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO
);

    localparam int unsigned            CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam int unsigned            SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_MAX = SETTLE_W'(SYNC_STAGES);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (SClk),
        .q     (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ss (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (SS),
        .q     (ss_s),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (MOSI),
        .q     (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

    spi_state_e            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;

    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign tx_bit     = tx_shift_q[0];
    assign tx_shifted = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
    assign rx_shifted = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
`else
    assign tx_bit     = tx_shift_q[DATA_WIDTH-1];
    assign tx_shifted = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
`endif

    logic      settled;
    logic      leading, trailing, sample_edge, word_load;
    spi_mode_t mode_dec;

    // The SS synchronizer resets to 1; arming waits until that reset value has
    // been flushed so a select held low through reset cannot start a frame.
    assign settled = (settle_q == SETTLE_MAX);

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        settle_d    = settled ? settle_q : settle_q + 1'b1;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        word_load   = 1'b0;
        mode_dec    = mode_decode(MODE);

        leading     = cpol_q ? sclk_fall : sclk_rise;
        trailing    = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = cpha_q ? trailing : leading;

        unique case (state_q)
            IDLE: begin
                if (settled && ss_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && ss_fall) begin
                    state_d   = ACTIVE;
                    cpol_d    = mode_dec.cpol;
                    cpha_d    = mode_dec.cpha;
                    bit_cnt_d = '0;
                    word_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    rx_shift_d = rx_shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_shifted;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // Bit 0 of every word is already on MISO after the load, so the
                // CPHA=1 leading edge of bit 0 must not shift.
                if (cpha_q) begin
                    if (trailing && bit_cnt_q == LAST_BIT) begin
                        word_load = 1'b1;
                    end else if (leading && bit_cnt_q != '0) begin
                        tx_shift_d = tx_shifted;
                    end
                end else if (trailing) begin
                    if (bit_cnt_q == '0) begin
                        word_load = 1'b1;
                    end else begin
                        tx_shift_d = tx_shifted;
                    end
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_d != '0) begin
                        frame_err_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_FILL;
                underrun_d = 1'b1;
            end
        end

        // A handshake coinciding with a load lands here, after the load has
        // already chosen its source, so it serves the following word.
        if (TxValid && !hold_full_q) begin
            hold_d      = TxData;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            settle_q    <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign TxReady  = ~hold_full_q;
    assign RxData   = rx_data_q;
    assign RxValid  = rx_valid_q;
    assign Underrun = underrun_q;
    assign FrameErr = frame_err_q;
    assign Busy     = (state_q == ACTIVE);
    assign MISO     = SS ? 1'bz : tx_bit;

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Next-generation SPI slave that runs entirely in the system clock domain. SClk, SS and MOSI are oversampled and edge-detected inside the block; SClk is never used as a clock.
- Supports all four SPI modes, any word width, and multi-word frames while SS stays low.
- Uses valid/ready handshakes for TX and a one-cycle valid pulse for RX.
- Sits between the SPI pins and the core logic, replacing the SClk-clocked slave.

Parameters:
- DATA_WIDTH, 8, bits per word (>= 2).
- SYNC_STAGES, 2, synchronizer flops on SClk/SS/MOSI (>= 2).
- TX_FILL, {DATA_WIDTH{1'b0}}, word shifted out when no TX data is held.

Ports:
- Clk  input  1  system clock; requires f(Clk) >= 4 x f(SClk).
- Rst_n  input  1  asynchronous, active-low reset.
- MODE  input  2  SPI mode {CPOL,CPHA}; latched at frame start.
- TxData  input  DATA_WIDTH  next word to transmit.
- TxValid  input  1  TxData valid.
- TxReady  output  1  TX holding register empty.
- RxData  output  DATA_WIDTH  last complete received word.
- RxValid  output  1  one-Clk pulse: RxData updated.
- Underrun  output  1  one-Clk pulse: word started with holding register empty.
- FrameErr  output  1  one-Clk pulse: SS rose mid-word.
- Busy  output  1  frame in progress (synchronized SS low and armed).
- SClk  input  1  SPI clock.
- MOSI  input  1  master out, slave in.
- SS  input  1  slave select, active low.
- MISO  output  1  master in, slave out; high-Z while raw SS = 1.

Behaviour:
- Reset values:
  - RxData = 0; RxValid, Underrun, FrameErr, Busy = 0; TxReady = 1; holding register empty; FSM in IDLE.
  - SS synchronizer resets to 1, SClk synchronizer to 0, Armed = 0.
- Synchronizers and edge detection:
  - SClk/SS/MOSI pass through SYNC_STAGES flops, then one extra flop for edge detect.
  - Edge-to-action latency is SYNC_STAGES+1 Clk cycles.
- Edge classification, using the CPOL latched at frame start:
  - Leading edge = SClk leaves its idle level; trailing edge = SClk returns to idle.
  - Sample edge = leading if CPHA = 0, trailing if CPHA = 1; the shift edge is the other one.
- FSM:
  - IDLE: sets Armed once synced SS = 1 has been seen. Synced SS falling while Armed -> ACTIVE: latch MODE, BitCnt = 0, load TxShift.
  - ACTIVE: on each sample edge, RxShift <= {RxShift, MOSI}. On the sample edge where BitCnt = DATA_WIDTH-1: RxData <= the completed word, RxValid pulses, BitCnt wraps to 0.
  - Synced SS rising -> IDLE. If BitCnt != 0, pulse FrameErr and discard the partial word; RxValid does not pulse.
- TX datapath:
  - Holding register: on TxValid && TxReady it captures TxData and TxReady drops.
  - Word load occurs at frame start, and at the trailing edge that ends bit DATA_WIDTH-1. At a word load, TxShift takes the holding register (TxReady returns to 1 next cycle); if the register is empty, TxShift takes TX_FILL and Underrun pulses.
  - Shifts happen on trailing edges when CPHA = 0, and on leading edges except bit 0 of each word when CPHA = 1.
  - MISO = TxShift MSB, gated to high-Z combinationally by raw SS.
- Simultaneous events:
  - A TxValid handshake in the same cycle as a word load is not used for that word; the word loads from the prior holding contents or TX_FILL, and the new data is captured for the following word.
  - SS rising in the same cycle as the final sample edge completes the word: RxValid = 1, FrameErr = 0.
- Reset mid-frame: all state returns to reset values. Transfers resume only after SS is seen high and then low again.
- Word arithmetic: BitCnt width is clog2(DATA_WIDTH) and wraps modulo DATA_WIDTH. MODE changes during ACTIVE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both shifters run LSB-first (MISO = TxShift[0], shift right; RX shifts into the MSB).
- Undefined: MSB-first as described above.
- Handshakes and timing are identical in both builds.

Decomposition:
- Package spi_pkg holds:
  - localparams for the mode encodings MODE0..MODE3;
  - the FSM state typedef (IDLE, ACTIVE);
  - a function that returns CPOL/CPHA from MODE.
- One sub-module, spi_sync_edge: a parameterised SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated three times.

Test Plan:
- Mode 0, TxData = 0x3C preloaded, master sends 0xA5 -> RxData = 0xA5 with one RxValid pulse, master receives 0x3C, TxReady returns to 1.
- Mode 3, 2-word frame, master sends 0x12, 0x34; slave TxData 0x81 then 0x7E, the second supplied mid-frame -> two RxValid pulses, MISO carries 0x81, 0x7E, no Underrun.
- Mode 1, no TxValid, TX_FILL = 0xFF -> Underrun pulses at frame start, MISO carries 0xFF, RX unaffected.
- Mode 2, SS raised after 5 bits -> FrameErr pulse, no RxValid, RxData unchanged, Busy = 0.
- Rst_n asserted mid-word with SS still low -> reset values. Remaining SClk edges ignored until SS toggles high then low; the next full frame 0x5A is received correctly.
- DATA_WIDTH = 16, mode 0, with SPI_SLAVE_LSB_FIRST_EN defined, master sends 0xBEEF LSB-first -> RxData = 0xBEEF.
